// File: rtl/l2_data_ram_arb.sv
// Arbiter/sequencer for a simple-dual-port L2 data array: zero-fills the array after
// reset, then round-robin arbitrates the read and write ports between refill (0) and core (1).
module l2_data_ram_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256,
  parameter int STRB_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  input  logic [2*STRB_W-1:0]   req_strob_i,
  output logic [1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  init_done_o,
  output logic                  ram_we_o,
  output logic [ADDR_W-1:0]     ram_waddr_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  output logic [STRB_W-1:0]     ram_wstrob_o,
  output logic                  ram_re_o,
  output logic [ADDR_W-1:0]     ram_raddr_o,
  input  logic [DATA_W-1:0]     ram_rdata_i
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                wr_rr_q, wr_rr_d;
  logic                rd_rr_q, rd_rr_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic                init_done_q, init_done_d;

  logic [ADDR_W-1:0]   addr0, addr1;
  logic [1:0]          wr_cand, rd_cand;
  logic                wr_any, rd_any;
  logic                wr_sel, rd_sel;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic                hazard, run;
  logic                wr_go, rd_go;
  logic [1:0]          wr_gnt, rd_gnt;

  assign addr0 = req_addr_i[ADDR_W-1:0];
  assign addr1 = req_addr_i[2*ADDR_W-1:ADDR_W];

  always_comb begin
    wr_cand = req_valid_i & req_we_i;
    rd_cand = req_valid_i & ~req_we_i;
    wr_any  = |wr_cand;
    rd_any  = |rd_cand;
    wr_sel  = (wr_cand == 2'b11) ? wr_rr_q : wr_cand[1];
    rd_sel  = (rd_cand == 2'b11) ? rd_rr_q : rd_cand[1];
    wr_addr = wr_sel ? addr1 : addr0;
    rd_addr = rd_sel ? addr1 : addr0;
    // A same-address read stalls behind the write so it sees the new data next cycle.
    hazard  = wr_any & rd_any & (wr_addr == rd_addr);
    run     = (state_q == ST_RUN) & rst_i;
    wr_go   = run & wr_any;
    rd_go   = run & rd_any & ~hazard;
    wr_gnt  = wr_go ? {wr_sel, ~wr_sel} : 2'b00;
    rd_gnt  = rd_go ? {rd_sel, ~rd_sel} : 2'b00;
  end

  assign req_ready_o = wr_gnt | rd_gnt;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wr_rr_d      = wr_rr_q;
    rd_rr_d      = rd_rr_q;
    rsp_valid_d  = rd_gnt;
    init_done_d  = init_done_q;
    ram_we_o     = 1'b0;
    ram_waddr_o  = wr_addr;
    ram_wdata_o  = wr_sel ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
    ram_wstrob_o = wr_sel ? req_strob_i[2*STRB_W-1:STRB_W] : req_strob_i[STRB_W-1:0];
    ram_re_o     = 1'b0;
    ram_raddr_o  = rd_addr;

    unique case (state_q)
      ST_INIT: begin
        ram_we_o     = rst_i;
        ram_waddr_o  = init_cnt_q;
        ram_wdata_o  = '0;
        ram_wstrob_o = '1;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        ram_we_o = wr_go;
        ram_re_o = rd_go;
        if (wr_go && (wr_cand == 2'b11)) wr_rr_d = ~wr_sel;
        if (rd_go && (rd_cand == 2'b11)) rd_rr_d = ~rd_sel;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      wr_rr_q     <= 1'b0;
      rd_rr_q     <= 1'b0;
      rsp_valid_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wr_rr_q     <= wr_rr_d;
      rd_rr_q     <= rd_rr_d;
      rsp_valid_q <= rsp_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // Reset masks a pending response immediately so in-flight read data is dropped.
  assign rsp_valid_o = rsp_valid_q & {2{rst_i}};
  assign rsp_data_o  = ram_rdata_i;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_l2_data_ram_arb.sv
// Directed bench for l2_data_ram_arb with a behavioural 1-cycle-latency array model.
module tb_l2_data_ram_arb;
  localparam int AW = 10;
  localparam int DW = 256;
  localparam int SW = 32;

  localparam logic [DW-1:0] D0 = {8{32'h0101_0010}};
  localparam logic [DW-1:0] D1 = {8{32'h0202_0020}};
  localparam logic [DW-1:0] D2 = {8{32'h1234_5678}};
  localparam logic [DW-1:0] D3 = {8{32'hCAFE_0006}};
  localparam logic [DW-1:0] PART = {224'h0, 32'hFFFF_FFFF};

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [1:0]       req_valid_i = '0;
  logic [1:0]       req_ready_o;
  logic [1:0]       req_we_i = '0;
  logic [2*AW-1:0]  req_addr_i = '0;
  logic [2*DW-1:0]  req_wdata_i = '0;
  logic [2*SW-1:0]  req_strob_i = '0;
  logic [1:0]       rsp_valid_o;
  logic [DW-1:0]    rsp_data_o;
  logic             init_done_o;
  logic             ram_we_o;
  logic [AW-1:0]    ram_waddr_o;
  logic [DW-1:0]    ram_wdata_o;
  logic [SW-1:0]    ram_wstrob_o;
  logic             ram_re_o;
  logic [AW-1:0]    ram_raddr_o;
  logic [DW-1:0]    ram_rdata_i = '0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [1024];

  always #5 clk_i = ~clk_i;

  l2_data_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strob_i(req_strob_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .init_done_o(init_done_o),
    .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
    .ram_wstrob_o(ram_wstrob_o), .ram_re_o(ram_re_o), .ram_raddr_o(ram_raddr_o),
    .ram_rdata_i(ram_rdata_i)
  );

  // Array model: byte-strobed write, registered read of the pre-write contents.
  always @(posedge clk_i) begin
    if (ram_re_o) ram_rdata_i <= mem[ram_raddr_o];
    if (ram_we_o)
      for (int b = 0; b < SW; b++)
        if (ram_wstrob_o[b]) mem[ram_waddr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid_i[n]          = v;
    req_we_i[n]             = we;
    req_addr_i[n*AW +: AW]  = a;
    req_wdata_i[n*DW +: DW] = d;
    req_strob_i[n*SW +: SW] = s;
  endtask

  task automatic rd_req(input int n, input logic [AW-1:0] a, output logic [DW-1:0] data,
                        output logic vld);
    int waits = 0;
    tick;
    set_req(n, 1'b1, 1'b0, a, '0, '0);
    #1;
    while (!req_ready_o[n] && waits < 8) begin
      tick; #1; waits++;
    end
    tick;
    req_valid_i[n] = 1'b0;
    #1;
    vld  = rsp_valid_o[n];
    data = rsp_data_o;
  endtask

  task automatic wr_req(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
    int waits = 0;
    tick;
    set_req(n, 1'b1, 1'b1, a, d, s);
    #1;
    while (!req_ready_o[n] && waits < 8) begin
      tick; #1; waits++;
    end
    tick;
    req_valid_i[n] = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    set_req(0, 1'b1, 1'b1, 10'h001, D0, '1);
    set_req(1, 1'b1, 1'b0, 10'h002, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick; #1;
    end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", ram_we_o); end
    total++; if (ram_re_o !== 1'b0) begin bad++; $display("FAIL rst_re: got %b want 0", ram_re_o); end
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", req_ready_o); end
    total++; if (rsp_valid_o !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid_o); end
    total++; if (init_done_o !== 1'b0) begin bad++; $display("FAIL rst_init_done: got %b want 0", init_done_o); end
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < 1024; i++) begin
      if (i != 0) begin tick; #1; end
      total++;
      if (ram_we_o !== 1'b1 || ram_waddr_o !== AW'(i) || ram_wdata_o !== '0 ||
          ram_wstrob_o !== '1 || req_ready_o !== 2'b00 || ram_re_o !== 1'b0 ||
          init_done_o !== 1'b0) begin
        bad++;
        $display("FAIL %s_cycle%0d: we=%b waddr=%h strb=%h ready=%b re=%b done=%b want we=1 waddr=%h strb=ffffffff ready=00 re=0 done=0",
                 tag, i, ram_we_o, ram_waddr_o, ram_wstrob_o, req_ready_o, ram_re_o, init_done_o, AW'(i));
      end
    end
    tick;
    req_valid_i = 2'b00;
    #1;
    total++; if (init_done_o !== 1'b1) begin bad++; $display("FAIL %s_done: got %b want 1", tag, init_done_o); end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL %s_idle_we: got %b want 0", tag, ram_we_o); end
  endtask

  task automatic test_init;
    logic [DW-1:0] d;
    logic v;
    tick;
    rst_i = 1'b1;
    set_req(0, 1'b1, 1'b0, 10'h000, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'h000, '0, '0);
    #1;
    run_init("init");
    rd_req(0, 10'h3FF, d, v);
    total++; if (v !== 1'b1 || d !== '0) begin bad++; $display("FAIL init_read_3ff: vld=%b data=%h want vld=1 data=0", v, d); end
    rd_req(1, 10'h155, d, v);
    total++; if (v !== 1'b1 || d !== '0) begin bad++; $display("FAIL init_read_155: vld=%b data=%h want vld=1 data=0", v, d); end
  endtask

  task automatic test_rr_writes;
    logic [DW-1:0] d;
    logic v;
    logic [1:0] eg;
    tick;
    set_req(0, 1'b1, 1'b1, 10'h010, D0, '1);
    set_req(1, 1'b1, 1'b1, 10'h020, D1, '1);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) begin tick; #1; end
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (req_ready_o !== eg || ram_we_o !== 1'b1 ||
          ram_waddr_o !== ((c % 2 == 0) ? 10'h010 : 10'h020) ||
          ram_wdata_o !== ((c % 2 == 0) ? D0 : D1)) begin
        bad++;
        $display("FAIL rr_write_c%0d: ready=%b we=%b waddr=%h want ready=%b we=1 waddr=%h",
                 c, req_ready_o, ram_we_o, ram_waddr_o, eg, (c % 2 == 0) ? 10'h010 : 10'h020);
      end
    end
    tick;
    req_valid_i = 2'b00;
    #1;
    rd_req(0, 10'h010, d, v);
    total++; if (v !== 1'b1 || d !== D0) begin bad++; $display("FAIL rr_readback_010: vld=%b data=%h want %h", v, d, D0); end
    rd_req(1, 10'h020, d, v);
    total++; if (v !== 1'b1 || d !== D1) begin bad++; $display("FAIL rr_readback_020: vld=%b data=%h want %h", v, d, D1); end
  endtask

  task automatic test_hazard;
    tick;
    set_req(0, 1'b1, 1'b1, 10'h123, D2, '1);
    set_req(1, 1'b1, 1'b0, 10'h123, '0, '0);
    #1;
    total++;
    if (req_ready_o !== 2'b01 || ram_we_o !== 1'b1 || ram_re_o !== 1'b0) begin
      bad++; $display("FAIL hazard_n: ready=%b we=%b re=%b want ready=01 we=1 re=0", req_ready_o, ram_we_o, ram_re_o);
    end
    tick;
    req_valid_i[0] = 1'b0;
    #1;
    total++;
    if (req_ready_o !== 2'b10 || ram_re_o !== 1'b1 || ram_raddr_o !== 10'h123) begin
      bad++; $display("FAIL hazard_n1: ready=%b re=%b raddr=%h want ready=10 re=1 raddr=123", req_ready_o, ram_re_o, ram_raddr_o);
    end
    tick;
    req_valid_i[1] = 1'b0;
    #1;
    total++;
    if (rsp_valid_o !== 2'b10 || rsp_data_o !== D2) begin
      bad++; $display("FAIL hazard_n2: rsp_valid=%b data=%h want rsp_valid=10 data=%h", rsp_valid_o, rsp_data_o, D2);
    end
  endtask

  task automatic test_parallel;
    logic [DW-1:0] d;
    logic v;
    tick;
    set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
    set_req(1, 1'b1, 1'b1, 10'h006, D3, '1);
    #1;
    total++;
    if (req_ready_o !== 2'b11 || ram_we_o !== 1'b1 || ram_re_o !== 1'b1 ||
        ram_raddr_o !== 10'h005 || ram_waddr_o !== 10'h006) begin
      bad++; $display("FAIL parallel_n: ready=%b we=%b re=%b raddr=%h waddr=%h want ready=11 we=1 re=1 raddr=005 waddr=006",
                      req_ready_o, ram_we_o, ram_re_o, ram_raddr_o, ram_waddr_o);
    end
    tick;
    req_valid_i = 2'b00;
    #1;
    total++;
    if (rsp_valid_o !== 2'b01 || rsp_data_o !== '0) begin
      bad++; $display("FAIL parallel_n1: rsp_valid=%b data=%h want rsp_valid=01 data=0", rsp_valid_o, rsp_data_o);
    end
    rd_req(1, 10'h006, d, v);
    total++; if (v !== 1'b1 || d !== D3) begin bad++; $display("FAIL parallel_readback: vld=%b data=%h want %h", v, d, D3); end
  endtask

  task automatic test_back_to_back;
    tick;
    set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
    set_req(1, 1'b1, 1'b0, 10'h020, '0, '0);
    #1;
    total++;
    if (req_ready_o !== 2'b01 || ram_raddr_o !== 10'h010) begin
      bad++; $display("FAIL b2b_c0: ready=%b raddr=%h want ready=01 raddr=010", req_ready_o, ram_raddr_o);
    end
    tick; #1;
    total++;
    if (req_ready_o !== 2'b10 || ram_raddr_o !== 10'h020 || rsp_valid_o !== 2'b01 || rsp_data_o !== D0) begin
      bad++; $display("FAIL b2b_c1: ready=%b raddr=%h rsp_valid=%b data=%h want ready=10 raddr=020 rsp_valid=01 data=%h",
                      req_ready_o, ram_raddr_o, rsp_valid_o, rsp_data_o, D0);
    end
    tick;
    req_valid_i = 2'b00;
    #1;
    total++;
    if (rsp_valid_o !== 2'b10 || rsp_data_o !== D1) begin
      bad++; $display("FAIL b2b_c2: rsp_valid=%b data=%h want rsp_valid=10 data=%h", rsp_valid_o, rsp_data_o, D1);
    end
  endtask

  task automatic test_partial;
    logic [DW-1:0] d;
    logic v;
    wr_req(0, 10'h200, '1, 32'h0000_000F);
    rd_req(1, 10'h200, d, v);
    total++; if (v !== 1'b1 || d !== PART) begin bad++; $display("FAIL partial_write: vld=%b data=%h want %h", v, d, PART); end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d;
    logic v;
    tick;
    set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
    #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL midrst_xfer: ready=%b want 01", req_ready_o); end
    tick;
    req_valid_i = 2'b00;
    rst_i = 1'b0;
    #1;
    total++;
    if (rsp_valid_o !== 2'b00 || ram_we_o !== 1'b0 || ram_re_o !== 1'b0) begin
      bad++; $display("FAIL midrst_low: rsp_valid=%b we=%b re=%b want 00 0 0", rsp_valid_o, ram_we_o, ram_re_o);
    end
    tick;
    rst_i = 1'b1;
    #1;
    total++;
    if (rsp_valid_o !== 2'b00 || init_done_o !== 1'b0) begin
      bad++; $display("FAIL midrst_after: rsp_valid=%b done=%b want 00 0", rsp_valid_o, init_done_o);
    end
    run_init("reinit");
    rd_req(0, 10'h010, d, v);
    total++; if (v !== 1'b1 || d !== '0) begin bad++; $display("FAIL reinit_zeroed: vld=%b data=%h want 0", v, d); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {8{32'hA5A5_5A5A}} ^ DW'(i);
    test_reset;
    test_init;
    test_rr_writes;
    test_hazard;
    test_parallel;
    test_back_to_back;
    test_partial;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_data_ram_arb.md
# l2_data_ram_arb

Arbiter and sequencer for one 1024-entry × 256-bit simple-dual-port L2 data array (1 write port, 1 read port, 1-cycle read latency). After reset it zero-initialises the whole array, then shares the array between two requesters: requester 0 is the refill path and requester 1 is the core-access path. The read and write ports are arbitrated independently each cycle, and same-address read/write collisions are resolved by stalling the read.

## Interface
Parameters:
- ADDR_W, 10, array address width (depth = 2^ADDR_W)
- DATA_W, 256, data width
- STRB_W, 32, byte-strobe width (DATA_W/8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester accept; a request transfers when valid & ready
- req_we_i  in  2  1 = write, 0 = read
- req_addr_i  in  2×ADDR_W  per-requester address
- req_wdata_i  in  2×DATA_W  per-requester write data
- req_strob_i  in  2×STRB_W  per-requester byte strobes
- rsp_valid_o  out  2  read-data valid, per requester
- rsp_data_o  out  DATA_W  read data, shared, qualified by rsp_valid_o
- init_done_o  out  1  array initialisation complete
- ram_we_o, ram_waddr_o, ram_wdata_o, ram_wstrob_o  out  1/ADDR_W/DATA_W/STRB_W  array write port
- ram_re_o, ram_raddr_o  out  1/ADDR_W  array read port
- ram_rdata_i  in  DATA_W  array read data, valid the cycle after ram_re_o

## Operation
- FSM states:
  - INIT: entered on reset.
    - Counter init_cnt runs 0..2^ADDR_W-1, one write per cycle.
    - Each write drives ram_we_o=1, ram_waddr_o=init_cnt, ram_wdata_o=0, ram_wstrob_o=all ones.
    - ram_re_o=0 and req_ready_o=0.
    - At init_cnt = 2^ADDR_W-1 the FSM moves to RUN.
  - RUN: normal arbitration. There is no exit from RUN except reset.
- Write port (RUN):
  - Write candidates are requesters with valid=1 and we=1.
  - One candidate: that requester is granted.
  - Two candidates: the requester selected by wr_rr is granted, then wr_rr toggles to the loser.
- Read port (RUN):
  - Read candidates are requesters with valid=1 and we=0.
  - Same round-robin rule, using rd_rr.
- Hazard: if the granted read address equals the granted write address in the same cycle:
  - The read is not granted (ready=0). The write proceeds.
  - rd_rr is not updated.
  - The read retries on the next cycle.
- req_ready_o[n] = 1 only in RUN and only when requester n is granted in that cycle. The ready value for a non-valid requester is don't-care but must be 0.
- ram_we_o / ram_re_o are asserted only on a granted transfer, with address, data and strobe muxed from the winner.
- Read response:
  - rsp_valid_o[n] is registered: it is set the cycle after requester n's read transfer, for exactly one cycle.
  - rsp_data_o = ram_rdata_i, passed through combinationally.
- A requester may issue back-to-back reads. Throughput is one read plus one write per cycle in total.

## Timing
- Reset values: init_cnt=0, state=INIT, wr_rr=rd_rr=0 (requester 0 first), rsp_valid_o=0, init_done_o=0, req_ready_o=0.
- While rst_i is low, the write port is idle: ram_we_o=0 and ram_re_o=0.
- Initialisation timing:
  - INIT writes start on the first cycle with rst_i high.
  - They occupy exactly 2^ADDR_W cycles (1024 at default).
  - init_done_o is registered and goes high on the first RUN cycle.
- Read latency: transfer at cycle N produces rsp_valid_o at N+1, with data from ram_rdata_i.
- Write visibility: a write at cycle N is visible to a read transferred at N+1 or later.
- Hazard stall costs exactly one cycle per collision.
- Reset mid-operation:
  - The state returns to INIT and init_cnt to 0.
  - A pending rsp_valid_o is cleared; in-flight read data is dropped.
  - Round-robin pointers reset.
  - The array is re-zeroed.
- Requesters must hold addr, we, wdata and strob stable while valid=1 and ready=0.

## Test plan
- Reset, then hold rst_i high 1024 cycles. Required:
  - ram_we_o=1 on cycles 0..1023 with addresses 0..1023, wdata=0 and strobe 0xFFFFFFFF.
  - req_ready_o=0 throughout.
  - init_done_o=1 at cycle 1024.
  - After that, a read of address 0x3FF returns 0.
- RUN: both requesters continuously write (addr 0x010 and 0x020) for 4 cycles. Required: grants alternate r0, r1, r0, r1. Reading both addresses back returns the written data.
- r0 writes addr 0x123 and r1 reads 0x123 in the same cycle. Required:
  - Cycle N: write granted, read ready=0.
  - Cycle N+1: read granted.
  - Cycle N+2: rsp_valid_o[1]=1 with the new data.
- r0 reads 0x005 and r1 writes 0x006 in the same cycle. Required: both granted in cycle N, and rsp_valid_o[0]=1 at N+1.
- Partial write: write 0xFF…FF with strobe 0x0000000F to addr 0x200 after init. Required: a read returns 0x00…00FFFFFFFF (only the low 4 bytes set).
- Assert rst_i low for 1 cycle the cycle after a read transfer. Required: rsp_valid_o stays 0, init_done_o drops to 0, and the INIT sequence restarts at address 0.
